// File: rtl/lbm_stream.sv
// Streaming stage of the Lattice Boltzmann pipeline: reads the source lattice in raster
// order, moves each distribution byte to its neighbour (bounce-back at edges), writes it out.
module lbm_stream #(
  parameter  int WIDTH        = 205,
  parameter  int HEIGHT       = 154,
  parameter  int READ_LATENCY = 2,
  localparam int BRAM_DEPTH   = WIDTH * HEIGHT,
  localparam int AW           = $clog2(BRAM_DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  output logic                 rd_en_out,
  output logic [AW-1:0]        rd_addr_out,
  input  logic [8:0][7:0]      rd_data_in,
  output logic                 wr_en_out,
  output logic [AW-1:0]        wr_addr_out,
  output logic [8:0][7:0]      wr_data_out,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int L    = READ_LATENCY + WIDTH + 2;
  localparam int HIST = 2 * WIDTH + 2;
  localparam int SW   = $clog2(BRAM_DEPTH + L + 1);
  localparam int XW   = $clog2(WIDTH + 1);
  localparam int YW   = $clog2(HEIGHT + 1);

  localparam logic [SW-1:0] RD_LAST    = SW'(BRAM_DEPTH - 1);
  localparam logic [SW-1:0] DRAIN_LAST = SW'(BRAM_DEPTH + L - 1);
  localparam logic [SW-1:0] COMP_FIRST = SW'(L - 1);
  localparam logic [SW-1:0] COMP_LAST  = SW'(BRAM_DEPTH + L - 2);
  localparam logic [XW-1:0] X_LAST     = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic   [SW-1:0]    step;
  logic               active;
  logic               comp_en;
  logic   [XW-1:0]    dst_x;
  logic   [YW-1:0]    dst_y;
  logic   [AW-1:0]    dst_addr;
  logic   [8:0][7:0]  hist [HIST];
  logic   [8:0][7:0]  self_cell;
  logic   [8:0][7:0]  nxt_cell;
  logic               at_l, at_r, at_t, at_b;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_in)            state_nxt = S_READ;
      S_READ:  if (step == RD_LAST)     state_nxt = S_DRAIN;
      S_DRAIN: if (step == DRAIN_LAST)  state_nxt = S_DONE;
      S_DONE:                           state_nxt = S_IDLE;
      default:                          state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    active      = (state == S_READ) || (state == S_DRAIN);
    rd_en_out   = (state == S_READ);
    rd_addr_out = rd_en_out ? step[AW-1:0] : '0;
    busy_out    = active;
    done_out    = (state == S_DONE);
    comp_en     = active && (step >= COMP_FIRST) && (step <= COMP_LAST);
  end

  // step counts cycles since the pass began; it paces reads, writes and the drain.
  always_ff @(posedge clk_in) begin
    if (rst_in || !active) step <= '0;
    else                   step <= step + SW'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || !active) begin
      dst_x    <= '0;
      dst_y    <= '0;
      dst_addr <= '0;
    end else if (comp_en) begin
      dst_addr <= dst_addr + AW'(1);
      if (dst_x == X_LAST) begin
        dst_x <= '0;
        dst_y <= dst_y + YW'(1);
      end else begin
        dst_x <= dst_x + XW'(1);
      end
    end
  end

  // NOTE: the history window carries data only; it has no reset so it maps to plain
  // shift-register/SRL resources, and stale entries are only ever read under bounce-back.
  always_ff @(posedge clk_in) begin
    hist[0] <= rd_data_in;
    for (int j = 1; j < HIST; j++) hist[j] <= hist[j-1];
  end

  // hist[j] holds cell (m + WIDTH - j) for destination m; rd_data_in holds m + WIDTH + 1.
  always_comb begin
    at_l      = (dst_x == '0);
    at_r      = (dst_x == X_LAST);
    at_t      = (dst_y == '0);
    at_b      = (dst_y == Y_LAST);
    self_cell = hist[WIDTH];
    nxt_cell    = '0;
    nxt_cell[0] = self_cell[0];
    nxt_cell[1] = at_b          ? self_cell[5] : hist[0][1];
    nxt_cell[2] = (at_l || at_b) ? self_cell[6] : hist[1][2];
    nxt_cell[3] = at_l          ? self_cell[7] : hist[WIDTH+1][3];
    nxt_cell[4] = (at_l || at_t) ? self_cell[8] : hist[2*WIDTH+1][4];
    nxt_cell[5] = at_t          ? self_cell[1] : hist[2*WIDTH][5];
    nxt_cell[6] = (at_r || at_t) ? self_cell[2] : hist[2*WIDTH-1][6];
    nxt_cell[7] = at_r          ? self_cell[3] : hist[WIDTH-1][7];
    nxt_cell[8] = (at_r || at_b) ? self_cell[4] : rd_data_in[8];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_en_out   <= 1'b0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
    end else begin
      wr_en_out <= comp_en;
      if (comp_en) begin
        wr_addr_out <= dst_addr;
        wr_data_out <= nxt_cell;
      end
    end
  end

endmodule

// File: tb/tb_lbm_stream.sv
// Directed bench for lbm_stream on a 4x3 lattice with a scoreboard of expected writes
// built from a coordinate-based streaming model.
module tb_lbm_stream;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int RL = 2;
  localparam int N  = W * H;
  localparam int L  = RL + W + 2;
  localparam int AW = $clog2(N);

  typedef logic [8:0][7:0] cell_t;
  typedef struct {
    logic [AW-1:0] addr;
    cell_t         data;
  } wr_t;

  logic          clk_in   = 1'b0;
  logic          rst_in   = 1'b1;
  logic          start_in = 1'b0;
  logic          rd_en_out;
  logic [AW-1:0] rd_addr_out;
  cell_t         rd_data_in;
  logic          wr_en_out;
  logic [AW-1:0] wr_addr_out;
  cell_t         wr_data_out;
  logic          busy_out;
  logic          done_out;

  cell_t mem [2**AW];
  cell_t stage1 = '0;
  cell_t stage2 = '0;
  wr_t   sb [$];
  int    n_cmp = 0;
  int    n_mis = 0;

  lbm_stream #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(RL)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_in    (start_in),
    .rd_en_out   (rd_en_out),
    .rd_addr_out (rd_addr_out),
    .rd_data_in  (rd_data_in),
    .wr_en_out   (wr_en_out),
    .wr_addr_out (wr_addr_out),
    .wr_data_out (wr_data_out),
    .busy_out    (busy_out),
    .done_out    (done_out)
  );

  always #5 clk_in = ~clk_in;

  // Source BRAM with two cycles of read latency
  always @(posedge clk_in) begin
    stage1 <= mem[rd_addr_out];
    stage2 <= stage1;
  end
  assign rd_data_in = stage2;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected streamed lattice, derived from direction vectors and grid coordinates.
  task automatic push_expected();
    int dx [9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
    int dy [9] = '{0, -1, -1, 0, 1, 1, 1, 0, -1};
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        cell_t self_c;
        cell_t o;
        wr_t   e;
        self_c = mem[y*W + x];
        o      = '0;
        o[0]   = self_c[0];
        for (int i = 1; i < 9; i++) begin
          int sx;
          int sy;
          sx = x - dx[i];
          sy = y - dy[i];
          if (sx >= 0 && sx < W && sy >= 0 && sy < H) o[i] = mem[sy*W + sx][i];
          else                                        o[i] = self_c[((i + 3) % 8) + 1];
        end
        e.addr = AW'(y*W + x);
        e.data = o;
        sb.push_back(e);
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
  endtask

  // Drive start_in in an IDLE cycle (cycle 0 of a pass).
  task automatic start_pass();
    @(negedge clk_in);
    start_in = 1'b1;
    check("idle_busy", 72'(busy_out), 72'(0));
  endtask

  // Cycle-accurate checks for cycles 1 .. N+L+1 of one pass.
  task automatic run_pass(input bit keep_start);
    for (int t = 1; t <= N + L + 1; t++) begin
      @(negedge clk_in);
      if (!keep_start) start_in = 1'b0;
      check("rd_en", 72'(rd_en_out), 72'(t <= N));
      if (t <= N) check("rd_addr", 72'(rd_addr_out), 72'(t - 1));
      check("busy", 72'(busy_out), 72'(t <= N + L));
      check("done", 72'(done_out), 72'(t == N + L + 1));
      check("wr_en", 72'(wr_en_out), 72'(t > L && t <= N + L));
      if (wr_en_out) begin
        check("sb_nonempty", 72'(sb.size() != 0), 72'(1));
        if (sb.size() != 0) begin
          wr_t e;
          e = sb.pop_front();
          check("wr_addr", 72'(wr_addr_out), 72'(e.addr));
          check("wr_data", wr_data_out, e.data);
        end
      end
    end
  endtask

  initial begin
    cell_t c;

    clear_mem();
    repeat (3) @(negedge clk_in);
    check("rst_rd_en", 72'(rd_en_out), 72'(0));
    check("rst_rd_addr", 72'(rd_addr_out), 72'(0));
    check("rst_wr_en", 72'(wr_en_out), 72'(0));
    check("rst_busy", 72'(busy_out), 72'(0));
    check("rst_done", 72'(done_out), 72'(0));
    rst_in = 1'b0;

    // Uniform field, E bytes 15
    c    = {9{8'd1}};
    c[3] = 8'd15;
    for (int i = 0; i < N; i++) mem[i] = c;
    push_expected();
    start_pass();
    run_pass(1'b0);

    // Single impulse: N byte of cell (1,1)
    clear_mem();
    mem[5][1] = 8'd200;
    push_expected();
    start_pass();
    run_pass(1'b0);

    // Corner bounce with start_in held high across two passes
    clear_mem();
    mem[0][8] = 8'd77;
    push_expected();
    start_pass();
    run_pass(1'b1);
    @(negedge clk_in);
    check("gap_busy", 72'(busy_out), 72'(0));
    check("gap_rd_en", 72'(rd_en_out), 72'(0));
    check("gap_done", 72'(done_out), 72'(0));
    check("gap_wr_en", 72'(wr_en_out), 72'(0));
    push_expected();
    run_pass(1'b0);

    // Reset in cycle 12 aborts the pass
    for (int i = 0; i < N; i++) mem[i] = {$urandom, $urandom, $urandom};
    start_pass();
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk_in);
      start_in = 1'b0;
      if (t == 12) rst_in = 1'b1;
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    check("abort_rd_en", 72'(rd_en_out), 72'(0));
    check("abort_wr_en", 72'(wr_en_out), 72'(0));
    check("abort_busy", 72'(busy_out), 72'(0));
    for (int t = 0; t < 15; t++) begin
      @(negedge clk_in);
      check("abort_quiet", 72'({wr_en_out, done_out, busy_out}), 72'(0));
    end

    // Fresh pass on random data after the abort
    for (int i = 0; i < N; i++) mem[i] = {$urandom, $urandom, $urandom};
    push_expected();
    start_pass();
    run_pass(1'b0);

    check("sb_drained", 72'(sb.size()), 72'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/lbm_stream.md
Name: lbm_stream

Overview:
- Streaming stage of the Lattice Boltzmann pipeline. Runs directly after the collision pass has written post-collision distributions to the lattice BRAM.
- Reads every lattice cell once, in raster order, from the source BRAM.
- Moves each of the 9 distribution bytes to its neighbouring cell, applying bounce-back at the grid edges.
- Writes the streamed lattice, in raster order, to the destination (ping-pong) BRAM.

Parameters:
- WIDTH, 205, lattice columns.
- HEIGHT, 154, lattice rows.
- BRAM_DEPTH, WIDTH*HEIGHT, number of cells. Derived; do not override.
- READ_LATENCY, 2, cycles from rd_addr_out to valid rd_data_in.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- start_in  input  1  begin one streaming pass; sampled only in IDLE.
- rd_en_out  output  1  read request to source BRAM.
- rd_addr_out  output  $clog2(BRAM_DEPTH)  source cell address.
- rd_data_in  input  [8:0][7:0]  source cell distributions.
- wr_en_out  output  1  write strobe to destination BRAM.
- wr_addr_out  output  $clog2(BRAM_DEPTH)  destination cell address.
- wr_data_out  output  [8:0][7:0]  streamed distributions.
- busy_out  output  1  pass in progress.
- done_out  output  1  one-cycle pulse when pass complete.

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset: all outputs are 0, FSM enters IDLE, internal window/line buffers are don't-care. Reset mid-pass aborts immediately: no further wr_en_out, no done_out pulse.
- Lattice layout:
  - addr = y*WIDTH + x; y=0 is the top row; north = y-1; east = x+1.
  - Byte order: 0 center, 1 N, 2 NE, 3 E, 4 SE, 5 S, 6 SW, 7 W, 8 NW.
  - opp(0)=0; opp(i) = ((i+3) mod 8)+1 for i=1..8 (1<->5, 2<->6, 3<->7, 4<->8).
- Streaming rule for destination cell (x,y), direction i with unit vector (dx,dy):
  - Source cell is (x-dx, y-dy).
  - Source inside grid: out[i] = src[i].
  - Source outside grid: out[i] = self[opp(i)] (bounce-back).
  - out[0] = self[0].
  - No arithmetic; bytes are copied unchanged.
- Window: destination m needs source cells m-WIDTH-1 .. m+WIDTH+1. Hold 2*WIDTH+3 cells of history (line-buffer RAM or shift register). Edge detection uses x/y counters, not address division.
- FSM states:
  - IDLE: start_in=1 -> READ.
  - READ: issues BRAM_DEPTH reads -> DRAIN.
  - DRAIN: emits remaining writes, no reads -> DONE.
  - DONE: one cycle -> IDLE.
- Timing (cycle 0 = IDLE cycle where start_in is sampled high; L = READ_LATENCY+WIDTH+2):
  - rd_en_out=1, rd_addr_out=m in cycle 1+m, for m = 0..BRAM_DEPTH-1.
  - wr_en_out=1, wr_addr_out=m, wr_data_out valid in cycle 1+m+L. Writes form one contiguous burst, addresses strictly ascending.
  - busy_out=1 in cycles 1 .. BRAM_DEPTH+L.
  - done_out=1 in cycle BRAM_DEPTH+L+1 only; busy_out=0 in that cycle.
- Output values when inactive:
  - rd_en_out=0 outside READ; rd_addr_out holds 0 in IDLE.
  - wr_en_out=0 outside the burst; wr_data_out/wr_addr_out don't-care.
- Ignored start_in: start_in is ignored while busy_out=1 and in the DONE cycle. A start_in in the cycle after done_out is accepted.
- Bottom-edge destinations in DRAIN never need data past the last cell (bounce-back); the read port stays idle.

Test Plan (WIDTH=4, HEIGHT=3, READ_LATENCY=2, so L=8, BRAM_DEPTH=12):
- Uniform field (all bytes 1, E byte 15) -> interior cells unchanged. Column x=0 gets out[3]=1. Column x=3 gets out[7]=15. Rows y=0 and y=2 keep N/S bytes 1.
- Single impulse: cell addr 5 (1,1) N=200, rest 0 -> addr 1 out[1]=200; all other bytes of all cells 0.
- Corner bounce: addr 0 NW=77, rest 0 -> addr 0 out[4]=77; all else 0.
- Timing: start_in at cycle 0 -> rd_addr 0..11 in cycles 1..12; wr_en cycles 9..20 with addr 0..11; busy cycles 1..20; done pulse only at cycle 21.
- start_in held high throughout -> second pass starts on the cycle-22 sample, not earlier; no overlap of bursts.
- rst_in asserted at cycle 12 -> from cycle 13: wr_en_out=0, busy_out=0, done_out never pulses. A new start then completes a correct full pass.
